// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 capture, VGA scan-out and LeNet stages.
// Frame geometry defaults, capture FSM states and small counter helpers.
package ov7670_pkg;

    typedef enum logic [1:0] {
        WAIT_VS,
        WAIT_FRAME,
        ACTIVE,
        HOLD
    } cap_state_t;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int FB_DEPTH  = H_RES_DEF * V_RES_DEF;
    localparam int FB_ADDR_W = $clog2(FB_DEPTH);
    localparam int CNT_W     = 10;

    // Saturating increment: the counter parks at lim instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v < lim) ? v + CNT_W'(1) : v;
    endfunction

endpackage

// File: rtl/ov7670_capture_if.sv
// Camera byte stream in, frame-buffer write port and frame status out.
// master = camera/controller side, slave = capture block.
interface ov7670_capture_if #(
    parameter int ADDR_W   = ov7670_pkg::FB_ADDR_W,
    parameter int PIX_BITS = 4
);
    logic                vsync;
    logic                href;
    logic [7:0]          din;
    logic                freeze;
    logic [ADDR_W-1:0]   wr_addr;
    logic [PIX_BITS-1:0] wr_pixel;
    logic                wr_en;
    logic                frame_done;
    logic                frame_full;
    logic                frozen;

    modport master (
        output vsync, href, din, freeze,
        input  wr_addr, wr_pixel, wr_en, frame_done, frame_full, frozen
    );

    modport slave (
        input  vsync, href, din, freeze,
        output wr_addr, wr_pixel, wr_en, frame_done, frame_full, frozen
    );
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 capture: keeps the luma byte of each pixel pair and writes its top bits
// into the frame buffer at line*H_RES+column, with optional freeze on frame end.
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int H_RES        = H_RES_DEF,
    parameter int V_RES        = V_RES_DEF,
    parameter int ADDR_W       = FB_ADDR_W,
    parameter int PIX_BITS     = 4,
    parameter bit LUMA_PHASE   = 1'b0,
    parameter bit VSYNC_ACTIVE = 1'b1
) (
    input  logic              pclk,
    input  logic              rst,
    ov7670_capture_if.slave   cam
);

    localparam logic [CNT_W-1:0]  H_MAX     = CNT_W'(H_RES);
    localparam logic [CNT_W-1:0]  V_MAX     = CNT_W'(V_RES);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_RES);

    logic                vs_q;
    logic                hr_q;
    logic                hr_qq;
    logic [PIX_BITS-1:0] d_q;

    cap_state_t          state;
    logic [CNT_W-1:0]    hcnt;
    logic [CNT_W-1:0]    vcnt;
    logic [ADDR_W-1:0]   line_base;
    logic                phase;
    logic                line_en;

    logic                vs_act;
    logic                hr_rise;
    logic                hr_fall;
    logic                in_line;
    logic                line_end;
    logic [CNT_W-1:0]    vcnt_nxt;

    assign vs_act   = (vs_q == VSYNC_ACTIVE);
    assign hr_rise  = hr_q & ~hr_qq;
    assign hr_fall  = ~hr_q & hr_qq;
    // A line counts only if href rose inside ACTIVE with vsync idle, so an href
    // that began during the vsync pulse never produces writes or line steps.
    assign in_line  = hr_q & (line_en | hr_rise) & ~vs_act;
    assign line_end = hr_fall & line_en;
    assign vcnt_nxt = line_end ? sat_inc(vcnt, V_MAX) : vcnt;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vs_q           <= 1'b0;
            hr_q           <= 1'b0;
            hr_qq          <= 1'b0;
            d_q            <= '0;
            state          <= WAIT_VS;
            hcnt           <= '0;
            vcnt           <= '0;
            line_base      <= '0;
            phase          <= 1'b0;
            line_en        <= 1'b0;
            cam.wr_en      <= 1'b0;
            cam.wr_addr    <= '0;
            cam.wr_pixel   <= '0;
            cam.frame_done <= 1'b0;
            cam.frame_full <= 1'b0;
            cam.frozen     <= 1'b0;
        end else begin
            vs_q  <= cam.vsync;
            hr_q  <= cam.href;
            hr_qq <= hr_q;
            d_q   <= cam.din[7 -: PIX_BITS];

            cam.wr_en      <= 1'b0;
            cam.frame_done <= 1'b0;

            case (state)
                WAIT_VS: begin
                    if (vs_act)
                        state <= WAIT_FRAME;
                end

                WAIT_FRAME: begin
                    if (!vs_act) begin
                        state     <= ACTIVE;
                        line_base <= '0;
                        hcnt      <= '0;
                        vcnt      <= '0;
                        phase     <= 1'b0;
                        line_en   <= 1'b0;
                    end
                end

                ACTIVE: begin
                    if (in_line) begin
                        phase   <= ~phase;
                        line_en <= 1'b1;
                        if (phase == LUMA_PHASE && hcnt < H_MAX && vcnt < V_MAX) begin
                            cam.wr_en    <= 1'b1;
                            cam.wr_addr  <= line_base + ADDR_W'(hcnt);
                            cam.wr_pixel <= d_q;
                        end
                        if (phase)
                            hcnt <= sat_inc(hcnt, H_MAX);
                    end else if (line_end) begin
                        vcnt    <= vcnt_nxt;
                        hcnt    <= '0;
                        phase   <= 1'b0;
                        line_en <= 1'b0;
                        if (vcnt < V_MAX)
                            line_base <= line_base + LINE_STEP;
                    end

                    // Line accounting above lands in the same cycle, so frame_full
                    // sees a line whose href fell together with the vsync rise.
                    if (vs_act) begin
                        cam.frame_done <= 1'b1;
                        cam.frame_full <= (vcnt_nxt == V_MAX);
                        if (cam.freeze) begin
                            state      <= HOLD;
                            cam.frozen <= 1'b1;
                        end else begin
                            state      <= WAIT_FRAME;
                        end
                    end
                end

                HOLD: begin
                    if (!cam.freeze && vs_act) begin
                        state      <= WAIT_FRAME;
                        cam.frozen <= 1'b0;
                    end
                end

                default: state <= WAIT_VS;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench: two captures (luma on even / odd byte) share one camera
// stream on a reduced 8x6 geometry; expected writes and frame ends are queued.
`timescale 1ns/1ps
module tb_ov7670_capture;

    localparam int H  = 8;
    localparam int V  = 6;
    localparam int AW = 8;
    localparam int PB = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [PB-1:0] pix;
        int            cyc;
    } wr_t;

    typedef struct {
        logic full;
        int   cyc;
    } done_t;

    logic       pclk = 1'b0;
    logic       rst  = 1'b1;
    logic       vsync, href, freeze;
    logic [7:0] din;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    wr_t   wq0[$];
    wr_t   wq1[$];
    done_t dq0[$];
    done_t dq1[$];

    bit prev_cap  = 1'b0;
    bit prev_full = 1'b0;
    int f_lines, f_px, f_pat, f_short_idx, f_short_len, f_rst_line;
    int f_frz_on, f_frz_off, f_frozen_exp;
    bit f_cap, f_hvs, f_tight;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    ov7670_capture_if #(.ADDR_W(AW), .PIX_BITS(PB)) bus0 ();
    ov7670_capture_if #(.ADDR_W(AW), .PIX_BITS(PB)) bus1 ();

    assign bus0.vsync  = vsync;
    assign bus0.href   = href;
    assign bus0.din    = din;
    assign bus0.freeze = freeze;
    assign bus1.vsync  = vsync;
    assign bus1.href   = href;
    assign bus1.din    = din;
    assign bus1.freeze = freeze;

    ov7670_capture #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .PIX_BITS(PB),
                     .LUMA_PHASE(1'b0), .VSYNC_ACTIVE(1'b1))
        dut0 (.pclk(pclk), .rst(rst), .cam(bus0.slave));

    ov7670_capture #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .PIX_BITS(PB),
                     .LUMA_PHASE(1'b1), .VSYNC_ACTIVE(1'b1))
        dut1 (.pclk(pclk), .rst(rst), .cam(bus1.slave));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic chk_wr(input int i, input logic [AW-1:0] a, input logic [PB-1:0] p);
        wr_t e;
        bit  have;
        have = 1'b0;
        if (i == 0 && wq0.size() > 0) begin e = wq0.pop_front(); have = 1'b1; end
        if (i == 1 && wq1.size() > 0) begin e = wq1.pop_front(); have = 1'b1; end
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL unexpected_write dut%0d: got addr=%0d pix=%h cyc=%0d, required no write",
                     i, a, p, cyc);
        end else if (a !== e.addr || p !== e.pix || cyc != e.cyc) begin
            errors++;
            $display("FAIL write dut%0d: got addr=%0d pix=%h cyc=%0d, required addr=%0d pix=%h cyc=%0d",
                     i, a, p, cyc, e.addr, e.pix, e.cyc);
        end
    endtask

    task automatic chk_done(input int i, input logic full);
        done_t e;
        bit    have;
        have = 1'b0;
        if (i == 0 && dq0.size() > 0) begin e = dq0.pop_front(); have = 1'b1; end
        if (i == 1 && dq1.size() > 0) begin e = dq1.pop_front(); have = 1'b1; end
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL unexpected_frame_done dut%0d: got full=%b cyc=%0d, required no pulse", i, full, cyc);
        end else if (full !== e.full || cyc != e.cyc) begin
            errors++;
            $display("FAIL frame_done dut%0d: got full=%b cyc=%0d, required full=%b cyc=%0d",
                     i, full, cyc, e.full, e.cyc);
        end
    endtask

    // Monitor: every DUT output event is matched against the queued expectation.
    always @(negedge pclk) begin
        if (bus0.wr_en === 1'b1)      chk_wr(0, bus0.wr_addr, bus0.wr_pixel);
        if (bus1.wr_en === 1'b1)      chk_wr(1, bus1.wr_addr, bus1.wr_pixel);
        if (bus0.frame_done === 1'b1) chk_done(0, bus0.frame_full);
        if (bus1.frame_done === 1'b1) chk_done(1, bus1.frame_full);
    end

    task automatic drive(input logic v, input logic h, input logic [7:0] d);
        vsync = v;
        href  = h;
        din   = d;
        @(negedge pclk);
    endtask

    task automatic reset_checks();
        chk("rst_wr_en0",      32'(bus0.wr_en),      32'd0);
        chk("rst_wr_addr0",    32'(bus0.wr_addr),    32'd0);
        chk("rst_wr_pixel0",   32'(bus0.wr_pixel),   32'd0);
        chk("rst_frame_done0", 32'(bus0.frame_done), 32'd0);
        chk("rst_frame_full0", 32'(bus0.frame_full), 32'd0);
        chk("rst_frozen0",     32'(bus0.frozen),     32'd0);
        chk("rst_wr_en1",      32'(bus1.wr_en),      32'd0);
        chk("rst_frozen1",     32'(bus1.frozen),     32'd0);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        vsync = 1'b0;
        href  = 1'b0;
        din   = 8'h00;
        @(negedge pclk);
        reset_checks();
        @(negedge pclk);
        rst   = 1'b0;
        f_cap = 1'b0;
    endtask

    function automatic logic [7:0] byte_even(input int pat, input int row, input int col);
        logic [3:0] c, r;
        c = 4'(col);
        r = 4'(row);
        return (pat == 0) ? 8'hA5 : {c, r};
    endfunction

    function automatic logic [7:0] byte_odd(input int pat, input int row, input int col);
        logic [3:0] c, r;
        c = 4'(col);
        r = 4'(row);
        return (pat == 0) ? 8'h3C : {c ^ 4'h6, r};
    endfunction

    // Opening vsync pulse; it also closes the previous frame.
    task automatic vsync_pulse(input bit hvs);
        done_t e;
        if (prev_cap) begin
            e.full = prev_full;
            e.cyc  = cyc + 2;
            dq0.push_back(e);
            dq1.push_back(e);
        end
        prev_cap = 1'b0;
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, hvs,  8'hF0);
        drive(1'b1, hvs,  8'hE1);
        drive(1'b1, 1'b0, 8'h00);
    endtask

    task automatic cfg(input int lines, input int px, input int pat, input bit cap);
        f_lines = lines; f_px = px; f_pat = pat; f_cap = cap;
        f_short_idx = -1; f_short_len = 0; f_rst_line = -1;
        f_frz_on = -1; f_frz_off = -1; f_frozen_exp = -1;
        f_hvs = 1'b0; f_tight = 1'b0;
    endtask

    task automatic run_frame();
        int         n;
        wr_t        e;
        logic [7:0] b0, b1;
        vsync_pulse(f_hvs);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        if (f_frozen_exp >= 0) begin
            chk("frozen0", 32'(bus0.frozen), 32'(f_frozen_exp));
            chk("frozen1", 32'(bus1.frozen), 32'(f_frozen_exp));
        end
        for (int ln = 0; ln < f_lines; ln++) begin
            if (ln == f_rst_line) do_reset();
            if (ln == f_frz_on)   freeze = 1'b1;
            if (ln == f_frz_off)  freeze = 1'b0;
            n = (ln == f_short_idx) ? f_short_len : f_px;
            for (int col = 0; col < n; col++) begin
                b0 = byte_even(f_pat, ln, col);
                b1 = byte_odd(f_pat, ln, col);
                e.addr = AW'(ln * H + col);
                if (f_cap && col < H && ln < V) begin
                    e.pix = b0[7:4]; e.cyc = cyc + 2; wq0.push_back(e);
                end
                drive(1'b0, 1'b1, b0);
                if (f_cap && col < H && ln < V) begin
                    e.pix = b1[7:4]; e.cyc = cyc + 2; wq1.push_back(e);
                end
                drive(1'b0, 1'b1, b1);
            end
            if (!(f_tight && ln == f_lines - 1)) begin
                drive(1'b0, 1'b0, 8'h00);
                drive(1'b0, 1'b0, 8'h00);
            end
        end
        if (!f_tight) begin
            drive(1'b0, 1'b0, 8'h00);
            drive(1'b0, 1'b0, 8'h00);
        end
        prev_cap  = f_cap;
        prev_full = (f_lines >= V);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vsync = 1'b0; href = 1'b0; din = 8'h00; freeze = 1'b0; rst = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        reset_checks();
        rst = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 8'h00);

        // Frame abandoned by a mid-frame reset, then a clean full frame.
        cfg(V, H, 0, 1'b1); f_rst_line = 3; run_frame();
        cfg(V, H, 0, 1'b1); run_frame();

        // Column pattern; freeze pulsed mid-frame; last href falls with vsync rise.
        cfg(V, H, 1, 1'b1); f_frz_on = 1; f_frz_off = 3; f_tight = 1'b1; run_frame();

        // Overlong lines and too many lines are clipped.
        cfg(9, 11, 1, 1'b1); run_frame();

        // Short frame with one short line; href raised inside the opening vsync.
        cfg(4, H, 1, 1'b1); f_short_idx = 2; f_short_len = 3; f_hvs = 1'b1; run_frame();

        // Freeze at frame end, two held frames, release, capture resumes.
        cfg(V, H, 1, 1'b1); f_frz_on = 2; run_frame();
        cfg(V, H, 0, 1'b0); f_frozen_exp = 1; run_frame();
        cfg(V, H, 0, 1'b0); f_frozen_exp = 1; f_frz_off = 2; run_frame();
        cfg(V, H, 1, 1'b1); f_frozen_exp = 0; f_hvs = 1'b1; run_frame();

        vsync_pulse(1'b0);
        repeat (6) drive(1'b0, 1'b0, 8'h00);

        chk("writes_left0", 32'(wq0.size()), 32'd0);
        chk("writes_left1", 32'(wq1.size()), 32'd0);
        chk("dones_left0",  32'(dq0.size()), 32'd0);
        chk("dones_left1",  32'(dq1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
